invntt_host_ctrl: RTL and testbench

//  Host-side initiator for the invntt core. Streams N=2^DEPTH input coefficients into
//  the core's input RAM, starts the computation, waits for done, then drains the N results.

---
 rtl/invntt_host_ctrl_if.sv | 39 +++
 rtl/invntt_host_ctrl.sv | 136 +++++++++++++
 tb/tb_invntt_host_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/invntt_host_ctrl_if.sv
// rtl/invntt_host_ctrl_if.sv - host, stream and invntt core handshake bundle
interface invntt_host_ctrl_if #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16
);
  logic              start;
  logic              busy;
  logic              done;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              core_readin;
  logic              core_readin_ok;
  logic              core_wr_en;
  logic [DEPTH-1:0]  core_wr_addr;
  logic [DATA_W-1:0] core_wr_data;
  logic              core_full_in;
  logic              core_cal_en;
  logic              core_done;
  logic [DEPTH-1:0]  core_rd_addr;
  logic [DATA_W-1:0] core_rd_data;
  logic              core_full_out;

  modport master (
    input  start, s_valid, s_data, m_ready, core_readin_ok, core_done, core_rd_data,
    output busy, done, s_ready, m_valid, m_data, m_last, core_readin, core_wr_en,
           core_wr_addr, core_wr_data, core_full_in, core_cal_en, core_rd_addr, core_full_out
  );

  modport slave (
    output start, s_valid, s_data, m_ready, core_readin_ok, core_done, core_rd_data,
    input  busy, done, s_ready, m_valid, m_data, m_last, core_readin, core_wr_en,
           core_wr_addr, core_wr_data, core_full_in, core_cal_en, core_rd_addr, core_full_out
  );
endinterface

// File: rtl/invntt_host_ctrl.sv
// rtl/invntt_host_ctrl.sv - host-side load/compute/drain sequencer for the invntt core
module invntt_host_ctrl #(
  parameter int DEPTH      = 8,
  parameter int DATA_W     = 16,
  parameter int READIN_CYC = 2
) (
  input logic                clk,
  input logic                reset,
  invntt_host_ctrl_if.master bus
);
  localparam int N  = 1 << DEPTH;
  localparam int CW = DEPTH + 1;
  localparam int TW = (READIN_CYC > 1) ? $clog2(READIN_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_N    = CW'(N);
  localparam logic [TW-1:0] T_LAST   = TW'(READIN_CYC - 1);

  typedef enum logic [6:0] {
    S_IDLE    = 7'b0000001,
    S_REQ     = 7'b0000010,
    S_LOAD    = 7'b0000100,
    S_CAL     = 7'b0001000,
    S_WAIT    = 7'b0010000,
    S_DRAIN   = 7'b0100000,
    S_RELEASE = 7'b1000000
  } state_t;

  state_t            state;
  logic [TW-1:0]     timer;
  logic [CW-1:0]     wcnt;
  logic [CW-1:0]     rcnt;
  logic [DATA_W-1:0] fifo_data [2];
  logic [1:0]        fifo_last;
  logic [1:0]        fifo_cnt;
  logic              fifo_head;
  logic              fifo_tail;
  logic              inflight;
  logic              inflight_last;
  logic              done_q;
  logic              wr_fire;
  logic              pop;
  logic              issue;
  logic [2:0]        occ;

  assign bus.busy          = (state != S_IDLE);
  assign bus.done          = done_q;
  assign bus.s_ready       = (state == S_LOAD) & bus.core_readin_ok;
  assign wr_fire           = bus.s_valid & bus.s_ready;
  assign bus.core_wr_en    = wr_fire;
  assign bus.core_wr_addr  = (state == S_LOAD) ? wcnt[DEPTH-1:0] : '0;
  assign bus.core_wr_data  = wr_fire ? bus.s_data : '0;
  assign bus.core_readin   = (state == S_REQ);
  assign bus.core_full_in  = (state == S_CAL);
  assign bus.core_cal_en   = (state == S_CAL) | (state == S_WAIT);
  assign bus.core_full_out = (state == S_RELEASE) & bus.core_done;
  assign bus.core_rd_addr  = (state == S_DRAIN) ? rcnt[DEPTH-1:0] : '0;

  // Result skid FIFO: reads land one cycle after issue, so credit counts the read in flight.
  assign bus.m_valid = (fifo_cnt != 2'd0);
  assign bus.m_data  = bus.m_valid ? fifo_data[fifo_head] : '0;
  assign bus.m_last  = bus.m_valid & fifo_last[fifo_head];
  assign pop         = bus.m_valid & bus.m_ready;
  assign fifo_tail   = fifo_head ^ fifo_cnt[0];
  assign occ         = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue       = (state == S_DRAIN) && (rcnt < CNT_N) && (occ < 3'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      timer         <= '0;
      wcnt          <= '0;
      rcnt          <= '0;
      fifo_data[0]  <= '0;
      fifo_data[1]  <= '0;
      fifo_last     <= '0;
      fifo_cnt      <= '0;
      fifo_head     <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && (rcnt == CNT_LAST);
      if (issue) rcnt <= rcnt + CW'(1);
      if (inflight) begin
        fifo_data[fifo_tail] <= bus.core_rd_data;
        fifo_last[fifo_tail] <= inflight_last;
      end
      fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
      if (pop) fifo_head <= ~fifo_head;

      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_REQ;
            timer <= '0;
          end
        end
        S_REQ: begin
          if (timer == T_LAST) state <= S_LOAD;
          else                 timer <= timer + TW'(1);
        end
        S_LOAD: begin
          if (wr_fire) begin
            if (wcnt == CNT_LAST) begin
              wcnt  <= '0;
              state <= S_CAL;
            end else begin
              wcnt <= wcnt + CW'(1);
            end
          end
        end
        S_CAL: begin
          if (!bus.core_readin_ok) state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.core_done) begin
            state <= S_DRAIN;
            rcnt  <= '0;
          end
        end
        S_DRAIN: begin
          if (pop && bus.m_last) state <= S_RELEASE;
        end
        S_RELEASE: begin
          if (!bus.core_done) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_invntt_host_ctrl.sv
// tb/tb_invntt_host_ctrl.sv - randomized directed bench for invntt_host_ctrl with a behavioural core
module tb_invntt_host_ctrl;
  localparam int DEPTH      = 8;
  localparam int DATA_W     = 16;
  localparam int READIN_CYC = 2;
  localparam int N          = 1 << DEPTH;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  invntt_host_ctrl_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

  invntt_host_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W), .READIN_CYC(READIN_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int done_pulses = 0;

  logic [DATA_W-1:0] in_ram  [N];
  logic [DATA_W-1:0] out_ram [N];
  logic [DATA_W-1:0] exp_in  [N];
  logic [DATA_W-1:0] exp_out [N];
  logic [DATA_W-1:0] rd_q = '0;

  // Core model: input RAM written on strobe, result RAM read with one cycle latency.
  always @(posedge clk) begin
    if (bus.core_wr_en) in_ram[bus.core_wr_addr] <= bus.core_wr_data;
    rd_q <= out_ram[bus.core_rd_addr];
  end
  assign bus.core_rd_data = rd_q;

  always @(negedge clk) if (bus.done === 1'b1) done_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".ctrl"}, {bus.busy, bus.done, bus.s_ready, bus.m_valid, bus.m_last,
                           bus.core_readin, bus.core_wr_en, bus.core_full_in,
                           bus.core_cal_en, bus.core_full_out}, 32'd0);
    check({tag, ".buses"}, {bus.core_wr_addr, bus.core_rd_addr, bus.core_wr_data}, 32'd0);
    check({tag, ".m_data"}, bus.m_data, 32'd0);
  endtask

  task automatic begin_run();
    @(negedge clk);
    bus.start = 1'b1;
    bus.core_readin_ok = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data = DATA_W'($urandom);
    #1;
    check("idle.busy", bus.busy, 32'd0);
    for (int i = 0; i < READIN_CYC; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      check("req.readin", {bus.core_readin, bus.busy}, 32'b11);
      check("req.no_accept", {bus.s_ready, bus.core_wr_en}, 32'd0);
    end
  endtask

  task automatic load(input int max_writes, input int gap_pct, input int ok_gap_at, output int cycles);
    int  w;
    logic ok;
    w = 0;
    cycles = 0;
    while (w < max_writes && cycles < 4 * N) begin
      @(negedge clk);
      ok = !(ok_gap_at >= 0 && cycles >= ok_gap_at && cycles < ok_gap_at + 3);
      bus.s_valid = ($urandom_range(99) >= gap_pct);
      bus.s_data = DATA_W'($urandom);
      bus.core_readin_ok = ok;
      #1;
      check("load.s_ready", bus.s_ready, ok);
      check("load.wr_en", bus.core_wr_en, bus.s_valid & ok);
      if (bus.s_valid && ok) begin
        check("load.wr_addr", bus.core_wr_addr, w);
        check("load.wr_data", bus.core_wr_data, bus.s_data);
        exp_in[w] = bus.s_data;
        w++;
      end
      cycles++;
    end
    check("load.writes", w, max_writes);
  endtask

  task automatic cal_wait(input int wait_cyc, input bit poke);
    @(negedge clk);
    #1;
    check("cal.enter", {bus.core_full_in, bus.core_cal_en, bus.s_ready, bus.core_wr_en}, 32'b1100);
    @(negedge clk);
    bus.core_readin_ok = 1'b0;
    #1;
    check("cal.hold", {bus.core_full_in, bus.core_cal_en}, 32'b11);
    @(negedge clk);
    #1;
    check("wait.full_in_drop", {bus.core_full_in, bus.core_cal_en}, 32'b01);
    for (int i = 0; i < wait_cyc; i++) begin
      @(negedge clk);
      bus.start = poke && (i == 1);
      #1;
      check("wait.state", {bus.busy, bus.core_cal_en, bus.core_full_in, bus.m_valid}, 32'b1100);
    end
    for (int i = 0; i < N; i++) begin
      out_ram[i] = in_ram[N-1-i] + 16'h1234;
      exp_out[i] = exp_in[N-1-i] + 16'h1234;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.core_done = 1'b1;
  endtask

  task automatic drain(input int mode, input bit poke, output int first_cyc, output int last_cyc);
    int beat;
    int cycles;
    logic held;
    logic [DATA_W-1:0] hd;
    logic hl;
    beat = 0;
    cycles = 0;
    held = 1'b0;
    first_cyc = 0;
    last_cyc = 0;
    while (beat < N && cycles < 8 * N) begin
      @(negedge clk);
      bus.m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(1)) : (cycles % 3 != 1);
      bus.start = poke && (cycles == 5);
      #1;
      if (held) begin
        check("drain.stall_valid", bus.m_valid, 32'd1);
        check("drain.stall_data", {bus.m_last, bus.m_data}, {hl, hd});
      end
      check("drain.busy", {bus.busy, bus.done}, 32'b10);
      if (bus.m_valid && bus.m_ready) begin
        if (beat == 0) first_cyc = cycles;
        last_cyc = cycles;
        check("drain.data", bus.m_data, exp_out[beat]);
        check("drain.last", bus.m_last, beat == N - 1);
        beat++;
      end
      held = bus.m_valid && !bus.m_ready;
      hd = bus.m_data;
      hl = bus.m_last;
      cycles++;
    end
    check("drain.beats", beat, N);
  endtask

  task automatic release_phase(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.m_ready = 1'b1;
      bus.core_done = 1'b1;
      #1;
      check("release.full_out", {bus.core_full_out, bus.done, bus.m_valid, bus.busy}, 32'b1001);
    end
    @(negedge clk);
    bus.core_done = 1'b0;
    #1;
    check("release.drop", {bus.core_full_out, bus.done, bus.busy}, 32'b001);
    @(negedge clk);
    #1;
    check("release.done_pulse", {bus.done, bus.busy}, 32'b10);
    @(negedge clk);
    #1;
    check("release.done_once", bus.done, 32'd0);
  endtask

  task automatic full_run(input int gap_pct, input int ok_gap_at, input int drain_mode,
                          input bit poke, input int hold, input bit thru);
    int lc, fc, lastc, d0;
    d0 = done_pulses;
    begin_run();
    load(N, gap_pct, ok_gap_at, lc);
    if (thru) check("t2.load_cycles", lc, N);
    cal_wait(4, poke);
    drain(drain_mode, poke, fc, lastc);
    if (thru) check("t2.drain_consecutive", lastc - fc, N - 1);
    release_phase(hold);
    check("run.done_count", done_pulses - d0, 32'd1);
  endtask

  initial begin
    int lc;
    bus.start = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.m_ready = 1'b0;
    bus.core_readin_ok = 1'b0;
    bus.core_done = 1'b0;
    for (int i = 0; i < N; i++) out_ram[i] = '0;

    repeat (2) @(negedge clk);
    #1;
    check_quiet("reset");
    reset = 1'b0;

    // T1: abort mid-load after 37 writes
    begin_run();
    load(37, 0, -1, lc);
    @(negedge clk);
    reset = 1'b1;
    bus.s_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_quiet("t1.after_reset");
    @(negedge clk);
    #1;
    check_quiet("t1.idle_hold");
    check("t1.no_done", done_pulses, 32'd0);

    // T2: full-rate run, load restarts from address 0
    full_run(0, -1, 0, 1'b0, 1, 1'b1);
    // T3: m_ready toggling and random stalls
    full_run(30, -1, 2, 1'b0, 1, 1'b0);
    full_run(10, -1, 1, 1'b0, 1, 1'b0);
    // T4: s_valid gaps and core_readin_ok low for 3 cycles mid-load
    full_run(25, 60, 1, 1'b0, 2, 1'b0);
    // T5: start pulses during WAIT and DRAIN
    full_run(0, -1, 1, 1'b1, 1, 1'b0);
    // T6: core_done held 4 cycles into RELEASE
    full_run(5, -1, 0, 1'b0, 4, 1'b0);

    @(negedge clk);
    #1;
    check_quiet("final.idle");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
